// File: rtl/seg_scan_capture.sv
// seg_scan_capture: recovers four hex digits from a scanned active-low 7-segment bus (optional dp capture via SEG_SCAN_CAPTURE_DP_EN).
// Latency: outputs update STABLE_CYCLES+1 edges after the bus settles; passive observer, no backpressure.
module seg_scan_capture #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic        clock_100Mhz,
   input  logic        reset_n,
   input  logic [3:0]  anode,
   input  logic [6:0]  cathode,
`ifdef SEG_SCAN_CAPTURE_DP_EN
   input  logic        dp,
   output logic [3:0]  digit_dp,
`endif
   output logic [15:0] digit_hex,
   output logic [3:0]  digit_valid,
   output logic        frame_done,
   output logic        no_scan,
   output logic [7:0]  err_count
);

   localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]      LP_STABLE = 8'(STABLE_CYCLES);
   localparam logic [TW-1:0]   LP_TO     = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]   LP_TO_M1  = TW'(TIMEOUT_CYCLES - 1);

   logic [3:0]    r_anode;
   logic [6:0]    r_cathode;
   logic [7:0]    r_stable;
   logic [TW-1:0] r_timeout;
   logic [3:0]    r_seen;
   logic          r_ill_d;
   logic [15:0]   r_digit_hex;
   logic [3:0]    r_digit_valid;
   logic          r_frame_done;
   logic          r_no_scan;
   logic [7:0]    r_err_count;

   logic          w_chg;
   logic [3:0]    w_sel;
   logic          w_legal;
   logic          w_blank;
   logic          w_ill;
   logic [7:0]    w_cnt_nxt;
   logic          w_latch;
   logic [1:0]    w_idx;
   logic [4:0]    w_dec;
   logic [15:0]   w_hex_upd;

   function automatic logic [4:0] f_decode(input logic [6:0] seg);
      case (seg)
         7'b0000001: f_decode = {1'b1, 4'h0};
         7'b1001111: f_decode = {1'b1, 4'h1};
         7'b0010010: f_decode = {1'b1, 4'h2};
         7'b0000110: f_decode = {1'b1, 4'h3};
         7'b1001100: f_decode = {1'b1, 4'h4};
         7'b0100100: f_decode = {1'b1, 4'h5};
         7'b0100000: f_decode = {1'b1, 4'h6};
         7'b0001111: f_decode = {1'b1, 4'h7};
         7'b0000000: f_decode = {1'b1, 4'h8};
         7'b0000100: f_decode = {1'b1, 4'h9};
         7'b0001000: f_decode = {1'b1, 4'hA};
         7'b1100000: f_decode = {1'b1, 4'hB};
         7'b0110001: f_decode = {1'b1, 4'hC};
         7'b1000010: f_decode = {1'b1, 4'hD};
         7'b0110000: f_decode = {1'b1, 4'hE};
         7'b0111000: f_decode = {1'b1, 4'hF};
         default:    f_decode = 5'b0_0000;
      endcase
   endfunction

`ifdef SEG_SCAN_CAPTURE_DP_EN
   logic       r_dp;
   logic [3:0] r_digit_dp;
   assign w_chg    = {anode, cathode, dp} != {r_anode, r_cathode, r_dp};
   assign digit_dp = r_digit_dp;
`else
   assign w_chg    = {anode, cathode} != {r_anode, r_cathode};
`endif

   assign w_sel   = ~r_anode;
   assign w_blank = (r_anode == 4'hF);
   assign w_legal = !w_blank && ((w_sel & (w_sel - 4'd1)) == 4'd0);
   assign w_ill   = !w_legal && !w_blank;

   // A new sample entering the input stage restarts the dwell; latch fires once on reaching the threshold.
   always_comb begin
      w_cnt_nxt = r_stable;
      if (w_chg || !w_legal)
         w_cnt_nxt = 8'd0;
      else if (r_stable != LP_STABLE)
         w_cnt_nxt = r_stable + 8'd1;
   end

   assign w_latch = (w_cnt_nxt == LP_STABLE) && (r_stable != LP_STABLE);
   assign w_dec   = f_decode(r_cathode);

   always_comb begin
      w_idx = 2'd0;
      case (r_anode)
         4'b1110: w_idx = 2'd0;
         4'b1101: w_idx = 2'd1;
         4'b1011: w_idx = 2'd2;
         4'b0111: w_idx = 2'd3;
         default: w_idx = 2'd0;
      endcase
   end

   always_comb begin
      w_hex_upd = r_digit_hex;
      w_hex_upd[{w_idx, 2'b00} +: 4] = w_dec[3:0];
   end

   always_ff @(posedge clock_100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_anode       <= 4'hF;
         r_cathode     <= 7'h7F;
         r_stable      <= 8'd0;
         r_timeout     <= '0;
         r_seen        <= 4'd0;
         r_ill_d       <= 1'b0;
         r_digit_hex   <= 16'd0;
         r_digit_valid <= 4'd0;
         r_frame_done  <= 1'b0;
         r_no_scan     <= 1'b0;
         r_err_count   <= 8'd0;
`ifdef SEG_SCAN_CAPTURE_DP_EN
         r_dp          <= 1'b1;
         r_digit_dp    <= 4'd0;
`endif
      end else begin
         r_anode      <= anode;
         r_cathode    <= cathode;
`ifdef SEG_SCAN_CAPTURE_DP_EN
         r_dp         <= dp;
`endif
         r_stable     <= w_cnt_nxt;
         r_ill_d      <= w_ill;
         r_frame_done <= 1'b0;

         if (w_ill && !r_ill_d && (r_err_count != 8'hFF))
            r_err_count <= r_err_count + 8'd1;

         // A latch takes priority over an expiring timeout in the same cycle.
         if (w_latch) begin
            r_digit_hex          <= w_hex_upd;
            r_digit_valid[w_idx] <= w_dec[4];
`ifdef SEG_SCAN_CAPTURE_DP_EN
            r_digit_dp[w_idx]    <= ~r_dp;
`endif
            r_timeout            <= '0;
            r_no_scan            <= 1'b0;
            if ((r_seen | w_sel) == 4'hF) begin
               r_seen       <= 4'd0;
               r_frame_done <= 1'b1;
            end else begin
               r_seen <= r_seen | w_sel;
            end
         end else if (r_timeout != LP_TO) begin
            r_timeout <= r_timeout + 1'b1;
            if (r_timeout == LP_TO_M1) begin
               r_no_scan     <= 1'b1;
               r_digit_valid <= 4'd0;
               r_seen        <= 4'd0;
            end
         end
      end
   end

   assign digit_hex   = r_digit_hex;
   assign digit_valid = r_digit_valid;
   assign frame_done  = r_frame_done;
   assign no_scan     = r_no_scan;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with STABLE_CYCLES=4, TIMEOUT_CYCLES=50.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_scan_capture;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  anode;
   logic [6:0]  cathode;
   logic [15:0] digit_hex;
   logic [3:0]  digit_valid;
   logic        frame_done;
   logic        no_scan;
   logic [7:0]  err_count;
`ifdef SEG_SCAN_CAPTURE_DP_EN
   logic        dp;
   logic [3:0]  digit_dp;
`endif

   int checks   = 0;
   int failures = 0;
   int frames   = 0;

   seg_scan_capture #(
      .STABLE_CYCLES (4),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .clock_100Mhz(clk),
      .reset_n     (reset_n),
      .anode       (anode),
      .cathode     (cathode),
`ifdef SEG_SCAN_CAPTURE_DP_EN
      .dp          (dp),
      .digit_dp    (digit_dp),
`endif
      .digit_hex   (digit_hex),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .no_scan     (no_scan),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold a pattern for n cycles, counting any frame_done pulses seen.
   task automatic dwell(input logic [3:0] an, input logic [6:0] cat, input int n);
      anode   = an;
      cathode = cat;
      repeat (n) begin
         @(negedge clk);
         if (frame_done === 1'b1) frames++;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      anode   = 4'hF;
      cathode = 7'h7F;
`ifdef SEG_SCAN_CAPTURE_DP_EN
      dp      = 1'b1;
`endif
      tick(3);
      check("rst_hex",   16'(digit_hex),   16'h0000);
      check("rst_valid", 16'(digit_valid), 16'h0000);
      check("rst_frame", 16'(frame_done),  16'h0000);
      check("rst_noscan",16'(no_scan),     16'h0000);
      check("rst_err",   16'(err_count),   16'h0000);

      // Single digit 1 on the rightmost position; latch on edge 5, not edge 4.
      reset_n = 1'b1;
      anode   = 4'b1110;
      cathode = 7'b1001111;
      tick(4);
      check("d0_edge4_hex",   16'(digit_hex),   16'h0000);
      check("d0_edge4_valid", 16'(digit_valid), 16'h0000);
      tick(1);
      check("d0_edge5_hex",   16'(digit_hex),   16'h0001);
      check("d0_edge5_valid", 16'(digit_valid), 16'h0001);
      check("d0_edge5_frame", 16'(frame_done),  16'h0000);
      tick(5);
      check("d0_hold_hex",    16'(digit_hex),   16'h0001);
      check("d0_hold_valid",  16'(digit_valid), 16'h0001);

      // Full scan 1,2,3,A.
      dwell(4'b1110, 7'b1001111, 8);
      dwell(4'b1101, 7'b0010010, 8);
      dwell(4'b1011, 7'b0000110, 8);
      check("scan_no_early_frame", 16'(frames), 16'd0);
      anode   = 4'b0111;
      cathode = 7'b0001000;
      tick(4);
      check("scan_frame_pre", 16'(frame_done), 16'h0000);
      tick(1);
      check("scan_frame_pulse", 16'(frame_done),  16'h0001);
      check("scan_hex",         16'(digit_hex),   16'hA321);
      check("scan_valid",       16'(digit_valid), 16'h000F);
      tick(1);
      check("scan_frame_post",  16'(frame_done),  16'h0000);
      tick(2);

      // Illegal anode entries: 1100 held counts once, then 0101 counts again.
      dwell(4'b1100, 7'b0001000, 6);
      check("ill_err1", 16'(err_count), 16'd1);
      dwell(4'b1111, 7'b0001000, 2);
      dwell(4'b0101, 7'b0001000, 6);
      check("ill_err2",   16'(err_count),   16'd2);
      check("ill_hex",    16'(digit_hex),   16'hA321);
      check("ill_valid",  16'(digit_valid), 16'h000F);
      check("ill_frames", 16'(frames),      16'd0);

      // Frame latched 17 cycles ago; 33 more blank cycles reach the timeout.
      dwell(4'b1111, 7'b0001000, 32);
      check("to_pre_noscan", 16'(no_scan),     16'h0000);
      check("to_pre_valid",  16'(digit_valid), 16'h000F);
      tick(1);
      check("to_noscan",     16'(no_scan),     16'h0001);
      check("to_valid",      16'(digit_valid), 16'h0000);
      dwell(4'b1111, 7'b0001000, 5);
      check("to_hold_noscan", 16'(no_scan), 16'h0001);
      anode   = 4'b1110;
      cathode = 7'b1001100;
      tick(4);
      check("to_exit_pre", 16'(no_scan), 16'h0001);
      tick(1);
      check("to_exit_noscan", 16'(no_scan),     16'h0000);
      check("to_exit_hex",    16'(digit_hex),   16'hA324);
      check("to_exit_valid",  16'(digit_valid), 16'h0001);
      tick(3);

      // Digit 2: legal 7, then an undecodable pattern.
      anode   = 4'b1011;
      cathode = 7'b0001111;
      tick(5);
      check("d2_hex",   16'(digit_hex),   16'hA724);
      check("d2_valid", 16'(digit_valid), 16'h0005);
      tick(1);
      cathode = 7'b1111110;
      tick(5);
      check("d2_bad_hex",   16'(digit_hex),   16'hA024);
      check("d2_bad_valid", 16'(digit_valid), 16'h0001);

      // Reset in the middle of a dwell.
      anode   = 4'b1101;
      cathode = 7'b0000000;
      tick(2);
      reset_n = 1'b0;
      #1;
      check("mid_rst_hex",    16'(digit_hex),   16'h0000);
      check("mid_rst_valid",  16'(digit_valid), 16'h0000);
      check("mid_rst_frame",  16'(frame_done),  16'h0000);
      check("mid_rst_noscan", 16'(no_scan),     16'h0000);
      check("mid_rst_err",    16'(err_count),   16'h0000);
      tick(2);
      reset_n = 1'b1;
      frames  = 0;

      // Fresh frame after reset: no pulse until all four digits relatch.
      dwell(4'b1101, 7'b0000000, 8);
      check("post_rst_d1_hex", 16'(digit_hex), 16'h0080);
      dwell(4'b1011, 7'b0000100, 8);
`ifdef SEG_SCAN_CAPTURE_DP_EN
      dp = 1'b0;
`endif
      dwell(4'b0111, 7'b0110000, 8);
`ifdef SEG_SCAN_CAPTURE_DP_EN
      dp = 1'b1;
`endif
      check("post_rst_no_frame", 16'(frames), 16'd0);
      dwell(4'b1110, 7'b1000010, 8);
      check("post_rst_frame", 16'(frames),      16'd1);
      check("post_rst_hex",   16'(digit_hex),   16'hE98D);
      check("post_rst_valid", 16'(digit_valid), 16'h000F);
`ifdef SEG_SCAN_CAPTURE_DP_EN
      check("dp_capture", 16'(digit_dp), 16'h0008);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_capture.md
SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive identical samples required before a digit is latched (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000: cycles without any latch before no_scan asserts (legal range ≥ 2).
REQ-003 SHALL have port clock_100Mhz, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port anode, input, 4: active-low digit select; bit 0 is the rightmost digit and bit 3 the leftmost.
REQ-006 SHALL have port cathode, input, 7: active-low segments {a,b,c,d,e,f,g}, with cathode[6] driving segment a.
REQ-007 SHALL have port digit_hex, output, 16: recovered nibbles; digit n is carried in bits [4n+3:4n].
REQ-008 SHALL have port digit_valid, output, 4: per-digit flag, set when the last latched pattern decoded legally.
REQ-009 SHALL have port frame_done, output, 1: one-cycle pulse when all four digits have been latched since the previous frame.
REQ-010 SHALL have port no_scan, output, 1: level indicating the scan timeout has expired.
REQ-011 SHALL have port err_count, output, 8: saturating count of illegal-anode events.

Function
REQ-012 SHALL register anode and cathode once on input (one-cycle input stage); all decisions use the registered copy.
REQ-013 SHALL classify registered anode: exactly one bit low → legal digit select; 4'b1111 → blank; any other value → illegal.
REQ-014 SHALL keep an 8-bit stable counter: clear on any change of {anode, cathode} or on blank/illegal; otherwise increment, saturating at STABLE_CYCLES.
REQ-015 SHALL latch the selected digit exactly once per dwell, in the cycle the counter first reaches STABLE_CYCLES; no re-latch until {anode, cathode} changes.
REQ-016 SHALL update digit_hex/digit_valid on the clock edge STABLE_CYCLES+1 edges after the input first presents a constant value.
REQ-017 SHALL decode cathode with the standard hex table (e.g. 7'b0000001 → 0, 7'b1001111 → 1, 7'b0001000 → A, 7'b0111000 → F); on a match, write the nibble and set the digit_valid bit.
REQ-018 SHALL, on an unmatched pattern, write nibble 4'h0 and clear that digit_valid bit.
REQ-019 SHALL set seen[n] on each latch of digit n; when the latch makes seen == 4'b1111, frame_done SHALL pulse in the same cycle the outputs update, and seen SHALL clear to 0 (the latching digit's bit is not retained).
REQ-020 SHALL increment err_count on each entry into an illegal anode state (transition from legal/blank to illegal), saturating at 255; a persisting illegal state counts once.
REQ-021 SHALL keep a timeout counter that increments every cycle without a latch, saturates at TIMEOUT_CYCLES, and clears on any latch.
REQ-022 SHALL assert no_scan when the timeout counter reaches TIMEOUT_CYCLES; at the same edge it SHALL clear digit_valid and seen.
REQ-023 SHALL deassert no_scan on the next latch, in the same cycle that latch updates digit_hex.
REQ-024 SHALL NOT increment any counter when the latch cycle and the timeout cycle coincide; the latch wins, no_scan stays 0 and the timeout counter clears.

Reset
REQ-025 SHALL, while reset_n is low, asynchronously clear digit_hex=0, digit_valid=0, frame_done=0, no_scan=0, err_count=0, seen=0, all counters=0, and input registers to anode=4'b1111, cathode=7'b1111111.
REQ-026 SHALL release reset synchronously in effect: the first count begins on the first rising edge after reset_n goes high.
REQ-027 SHALL discard any partial dwell or partial frame on reset assertion mid-operation; no frame_done follows reset until four new latches occur.

Configuration
REQ-028 SHALL, when SEG_SCAN_CAPTURE_DP_EN is defined, add input dp (1 bit, active-low) and output digit_dp (4 bits), include dp in the stability comparison, and latch ~dp into digit_dp[n] on each latch of digit n (reset value 0).
REQ-029 SHALL, when SEG_SCAN_CAPTURE_DP_EN is undefined, have neither port and behave exactly per REQ-012..REQ-027.

Verification (bench uses STABLE_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-030 SHALL cover: anode=4'b1110, cathode=7'b1001111 held 10 cycles → digit_hex[3:0]=1, digit_valid[0]=1 at edge 5; no second latch.
REQ-031 SHALL cover: scanning 1110/1101/1011/0111 with patterns 1,2,3,A at 8 cycles each → digit_hex=16'hA321, frame_done pulses once on the 4th latch.
REQ-032 SHALL cover: anode=4'b1100 for 6 cycles, then 4'b1111, then 4'b0101 → err_count=2, no latch, digit_hex unchanged.
REQ-033 SHALL cover: anode held 4'b1111 for 50 cycles after a frame → no_scan=1, digit_valid=0; the next legal dwell clears no_scan.
REQ-034 SHALL cover: cathode=7'b1111110 on digit 2 → digit_hex[11:8]=0, digit_valid[2]=0; reset_n pulsed low mid-dwell → all outputs 0 immediately.
REQ-035 SHALL cover, with SEG_SCAN_CAPTURE_DP_EN defined: dp=0 during the digit-3 dwell → digit_dp=4'b1000.
